lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane.sv | 40 ++++
 rtl/lsu.sv | 128 ++++++++++++
 tb/tb_lsu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes and FSM state encodings.
// Kept in one package so the decode stage can reuse the same encodings.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane handling: extracts and extends load data, and merges store data
// into an existing word for read-modify-write. Purely combinational.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v    = word[{lane, 3'b000} +: 8];
        half_v    = lane[1] ? word[31:16] : word[15:0];
        load_data = '0;
        merged    = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'd0, byte_v};
            F3_HU:   load_data = {16'd0, half_v};
            default: load_data = '0;
        endcase
        case (funct3)
            F3_B, F3_BU: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H, F3_HU: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default:     merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a single-port RAM with combinational reads.
// One request in flight; sub-word stores are done as read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter int SZ = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_w_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output lsu_state_t  dbg_state
);

    // Handshake: a request is accepted on a rising edge where req_valid && req_ready;
    // the response is a single-cycle resp_valid pulse with no backpressure.

    localparam logic [31:0] LAST_WORD = 32'(SZ - 4);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_err;
    logic [31:0] lane_word;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;
    logic        mem_access;

    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            F3_B:    req_err = 1'b0;
            F3_H:    req_err = req_addr[0];
            F3_W:    req_err = |req_addr[1:0];
            F3_BU:   req_err = req_we;
            F3_HU:   req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
        if ({req_addr[31:2], 2'b00} > LAST_WORD) req_err = 1'b1;
    end

    // In READ the live RAM word feeds the lanes; in WRITE the captured old word does.
    assign lane_word = (state == READ) ? mem_data_out : old_q;

    lsu_lane u_lane (
        .funct3    (f3_q),
        .lane      (addr_q[1:0]),
        .word      (lane_word),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= req_err;
                        if (req_err)                          state <= RESP;
                        else if (req_we && req_funct3 == F3_W) state <= WRITE;
                        else                                   state <= READ;
                    end
                end
                READ: begin
                    if (we_q) begin
                        old_q <= mem_data_out;
                        state <= WRITE;
                    end else begin
                        rdata_q <= lane_load;
                        state   <= RESP;
                    end
                end
                WRITE: state <= RESP;
                RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    old_q   <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is forced quiet while rst is high, so an aborted RMW never writes.
    assign mem_access  = !rst && (state == READ || state == WRITE);
    assign req_ready   = !rst && (state == IDLE);
    assign resp_valid  = !rst && (state == RESP);
    assign resp_rdata  = resp_valid ? rdata_q : '0;
    assign resp_err    = resp_valid & err_q;
    assign mem_w_en    = !rst && (state == WRITE);
    assign mem_addr    = mem_access ? {addr_q[31:2], 2'b00} : '0;
    assign mem_data_in = mem_w_en ? ((f3_q == F3_W) ? wdata_q : lane_merged) : '0;
    assign dbg_state   = rst ? IDLE : state;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed requests push expected {latency, err, rdata},
// a negedge monitor pops and compares on every resp_valid pulse.
module tb_lsu;
    import lsu_pkg::*;

    localparam int SZ = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    lsu_state_t  dbg_state;

    logic [31:0] ram [0:SZ/4-1];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wcount = 0;
    logic [31:0] last_waddr = '0;

    logic [34:0] exp_q[$];
    int          acc_q[$];

    always #5 clk = ~clk;

    lsu #(.SZ(SZ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_w_en     (mem_w_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .dbg_state    (dbg_state)
    );

    // RAM model: combinational read, write on the rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_w_en)   ram[mem_addr[11:2]] <= mem_data_in;
        else if (pl_en) ram[pl_addr[11:2]]  <= pl_data;
    end
    assign mem_data_out = ram[mem_addr[11:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [34:0] e;
        int a;
        if (rst) begin
            acc_q.delete();
            check("reset_quiet", {29'd0, mem_w_en, req_ready, resp_valid}, 32'd0);
        end else begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (mem_w_en) begin
                wcount++;
                last_waddr = mem_addr;
                check("waddr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
            end
            if (resp_valid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=resp_valid expected=none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("resp_rdata", resp_rdata, e[31:0]);
                    check("resp_err", 32'(resp_err), 32'(e[32]));
                    check("latency", 32'(cyc - a), 32'(e[34:33]));
                end
            end else begin
                check("rdata_idle", resp_rdata, 32'd0);
            end
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=no_ready expected=ready");
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=%0d_pending expected=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                         input logic [1:0] lat);
        exp_q.push_back({lat, err, rdata});
        @(posedge clk); #1;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();
    endtask

    int w0;

    initial begin
        preload(32'h20, 32'h1122_3344);
        preload(32'h30, 32'h8001_FFFE);
        preload(32'h40, 32'hCAFE_BABE);
        preload(32'hFFC, 32'hDEAD_BEEF);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        check("reset_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Word store then load
        w0 = wcount;
        issue(1'b1, F3_W, 32'h10, 32'h0000_007B, 1'b0, 32'h0, 2'd2);
        check("sw_wen_count", 32'(wcount - w0), 32'd1);
        check("sw_waddr", last_waddr, 32'h10);
        check("sw_ram", ram[4], 32'h0000_007B);
        issue(1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'h0000_007B, 2'd2);

        // Byte RMW then signed/unsigned byte loads
        w0 = wcount;
        issue(1'b1, F3_B, 32'h22, 32'h1234_56AB, 1'b0, 32'h0, 2'd3);
        check("sb_wen_count", 32'(wcount - w0), 32'd1);
        check("sb_ram", ram[8], 32'h11AB_3344);
        issue(1'b0, F3_B,  32'h22, 32'h0, 1'b0, 32'hFFFF_FFAB, 2'd2);
        issue(1'b0, F3_BU, 32'h22, 32'h0, 1'b0, 32'h0000_00AB, 2'd2);

        // Halfword loads, halfword RMW on the upper lane
        issue(1'b0, F3_H,  32'h32, 32'h0, 1'b0, 32'hFFFF_8001, 2'd2);
        issue(1'b0, F3_HU, 32'h30, 32'h0, 1'b0, 32'h0000_FFFE, 2'd2);
        issue(1'b1, F3_H,  32'h32, 32'h9999_5555, 1'b0, 32'h0, 2'd3);
        check("sh_ram", ram[12], 32'h5555_FFFE);
        issue(1'b0, F3_B,  32'h31, 32'h0, 1'b0, 32'hFFFF_FFFF, 2'd2);
        issue(1'b0, F3_HU, 32'h32, 32'h0, 1'b0, 32'h0000_5555, 2'd2);

        // Last legal word
        issue(1'b0, F3_W, 32'hFFC, 32'h0, 1'b0, 32'hDEAD_BEEF, 2'd2);

        // Rejected requests
        w0 = wcount;
        issue(1'b0, F3_W,  32'h13,     32'h0,  1'b1, 32'h0, 2'd1);
        issue(1'b1, F3_H,  32'h21,     32'hFF, 1'b1, 32'h0, 2'd1);
        issue(1'b0, F3_W,  32'(SZ),    32'h0,  1'b1, 32'h0, 2'd1);
        issue(1'b0, 3'd3,  32'h0,      32'h0,  1'b1, 32'h0, 2'd1);
        issue(1'b1, F3_BU, 32'h20,     32'h77, 1'b1, 32'h0, 2'd1);
        check("err_no_write", 32'(wcount - w0), 32'd0);
        check("err_ram_intact", ram[8], 32'h11AB_3344);

        // Reset during the READ cycle of a byte RMW
        w0 = wcount;
        @(posedge clk); #1;
        req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h40; req_wdata = 32'h55; req_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_in_read", 32'(dbg_state), 32'(READ));
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("abort_ram_intact", ram[16], 32'hCAFE_BABE);
        check("abort_no_write", 32'(wcount - w0), 32'd0);

        // Back-to-back loads with req_valid held high
        exp_q.push_back({2'd2, 1'b0, 32'h0000_007B});
        exp_q.push_back({2'd2, 1'b0, 32'h11AB_3344});
        @(posedge clk); #1;
        req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        req_addr = 32'h20;
        @(negedge clk);
        check("b2b_ready_read", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("b2b_ready_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("b2b_ready_next", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
